// File: rtl/output_packer.sv
// rtl/output_packer.sv - packs consecutive scaler beats into wide words and writes them to the output SRAM
// Beat k of a word lands in bits [k*B +: B]; a job always writes whole words from cfg base upward.
module output_packer #(
  parameter int numElements = 4,
  parameter int outputWidth = 8,
  parameter int wordWidth   = 64,
  parameter int addrWidth   = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_i,
  input  logic [addrWidth-1:0]               cfg_base_addr_i,
  input  logic [addrWidth-1:0]               cfg_num_words_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [numElements*outputWidth-1:0] data_i,
  output logic                               mem_we_o,
  output logic [addrWidth-1:0]               mem_addr_o,
  output logic [wordWidth-1:0]               mem_wdata_o,
  input  logic                               mem_ready_i,
  output logic                               busy_o,
  output logic                               done_o
);

  localparam int B            = numElements * outputWidth;
  localparam int BeatsPerWord = wordWidth / B;
  localparam int CntW         = (BeatsPerWord > 1) ? $clog2(BeatsPerWord) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(BeatsPerWord - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic [addrWidth-1:0] num_words_q, num_words_d;
  logic [addrWidth-1:0] word_cnt_q, word_cnt_d;
  logic [addrWidth-1:0] waddr_q, waddr_d;
  logic [CntW-1:0]      beat_q, beat_d;
  logic [wordWidth-1:0] pack_q, pack_d;
  logic [wordWidth-1:0] wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic                 done_q, done_d;
  logic                 stall, wr_hs, accept;

  always_comb begin
    stall   = we_q && !mem_ready_i;
    wr_hs   = we_q && mem_ready_i;
    ready_o = (state_q == RUN) && !stall;
    accept  = valid_i && ready_o;

    state_d     = state_q;
    addr_d      = addr_q;
    num_words_d = num_words_q;
    word_cnt_d  = word_cnt_q;
    waddr_d     = waddr_q;
    beat_d      = beat_q;
    pack_d      = pack_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    done_d      = 1'b0;

    // A reload below overrides this clear, giving back-to-back writes.
    if (wr_hs) we_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d      = cfg_base_addr_i;
          num_words_d = cfg_num_words_i;
          beat_d      = '0;
          word_cnt_d  = '0;
          if (cfg_num_words_i != '0) state_d = RUN;
          else                       done_d  = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          pack_d[int'(beat_q)*B +: B] = data_i;
          if (beat_q == LastBeat) begin
            we_d       = 1'b1;
            waddr_d    = addr_q;
            wdata_d    = pack_d;
            beat_d     = '0;
            addr_d     = addr_q + 1'b1;
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_q == num_words_q - 1'b1) state_d = DRAIN;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (wr_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      num_words_q <= '0;
      word_cnt_q  <= '0;
      waddr_q     <= '0;
      beat_q      <= '0;
      pack_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      num_words_q <= num_words_d;
      word_cnt_q  <= word_cnt_d;
      waddr_q     <= waddr_d;
      beat_q      <= beat_d;
      pack_q      <= pack_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      done_q      <= done_d;
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = waddr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_output_packer.sv
// tb/tb_output_packer.sv - self-checking bench for output_packer
module tb_output_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [9:0]  cfg_base_addr_i;
  logic [9:0]  cfg_num_words_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic        mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic        mem_ready_i;
  logic        busy_o;
  logic        done_o;

  always #5 clk = ~clk;

  output_packer dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .cfg_base_addr_i(cfg_base_addr_i), .cfg_num_words_i(cfg_num_words_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct {
    logic [9:0]        base;
    logic [3:0][31:0]  beats;
    int                stall;
    bit                gaps;
    logic [1:0][9:0]   exp_addr;
    logic [1:0][63:0]  exp_word;
  } vec_t;

  typedef struct packed {
    logic [9:0]  addr;
    logic [63:0] data;
  } wr_t;

  vec_t vecs[4];
  wr_t  exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   done_cnt = 0;
  int   n_writes = 0;
  int   stall_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out, got no event expected one", name);
  endtask

  // Memory side: stall the first stall_left cycles of a pending write
  initial begin
    mem_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (mem_we_o && stall_left > 0) begin
        mem_ready_i = 1'b0;
        stall_left--;
      end else begin
        mem_ready_i = 1'b1;
      end
    end
  end

  // Scoreboard monitor: pops an expected write on every memory handshake
  initial begin
    logic        held_v;
    logic [9:0]  held_addr;
    logic [63:0] held_data;
    wr_t         e;
    held_v = 1'b0;
    held_addr = '0;
    held_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (done_o) begin
          done_cnt++;
          chk("done_busy_low", 64'(busy_o), 64'd0);
        end
        if (held_v) begin
          chk("stall_addr_stable", 64'(mem_addr_o), 64'(held_addr));
          chk("stall_data_stable", mem_wdata_o, held_data);
        end
        if (mem_we_o && mem_ready_i) begin
          n_writes++;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr_o, mem_wdata_o);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(mem_addr_o), 64'(e.addr));
            chk("wr_data", mem_wdata_o, e.data);
          end
        end
        held_v    = mem_we_o && !mem_ready_i;
        held_addr = mem_addr_o;
        held_data = mem_wdata_o;
        if (held_v) chk("stall_blocks_ready", 64'(ready_o), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d);
    logic acc;
    bit   ok;
    ok = 0;
    valid_i = 1'b1;
    data_i  = d;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      acc = ready_o;
      tick();
      if (acc) begin
        ok = 1;
        break;
      end
    end
    valid_i = 1'b0;
    data_i  = $urandom;
    if (!ok) timeout("beat_accept");
  endtask

  task automatic push_exp(input vec_t v);
    wr_t e;
    for (int i = 0; i < 2; i++) begin
      e.addr = v.exp_addr[i];
      e.data = v.exp_word[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (done_cnt >= 1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout(name);
    repeat (3) tick();
  endtask

  task automatic run_job(input vec_t v, input string name);
    int w0;
    push_exp(v);
    done_cnt = 0;
    w0 = n_writes;
    stall_left = v.stall;
    start_i = 1'b1;
    cfg_base_addr_i = v.base;
    cfg_num_words_i = 10'd2;
    tick();
    start_i = 1'b0;
    cfg_base_addr_i = 10'($urandom);
    cfg_num_words_i = 10'($urandom);
    chk({name, "_start_busy"}, 64'(busy_o), 64'd1);
    chk({name, "_start_ready"}, 64'(ready_o), 64'd1);
    for (int b = 0; b < 4; b++) begin
      if (v.gaps) begin
        valid_i = 1'b0;
        tick();
      end
      send_beat(v.beats[b]);
    end
    wait_done({name, "_done"});
    chk({name, "_done_count"}, 64'(done_cnt), 64'd1);
    chk({name, "_write_count"}, 64'(n_writes - w0), 64'd2);
    chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_idle_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int   w0;
    vec_t v;

    vecs[0].base = 10'h010; vecs[0].stall = 0; vecs[0].gaps = 0;
    vecs[0].beats = {32'hFF007F80, 32'hF4F3F2F1, 32'h08070605, 32'h04030201};
    vecs[0].exp_addr = {10'h011, 10'h010};
    vecs[0].exp_word = {64'hFF007F80F4F3F2F1, 64'h0807060504030201};
    vecs[1] = vecs[0];
    vecs[1].stall = 3;
    vecs[2].base = 10'h3FF; vecs[2].stall = 0; vecs[2].gaps = 1;
    vecs[2].beats = {32'h00FFEEDD, 32'hCCBBAA99, 32'h88776655, 32'h44332211};
    vecs[2].exp_addr = {10'h000, 10'h3FF};
    vecs[2].exp_word = {64'h00FFEEDDCCBBAA99, 64'h8877665544332211};
    vecs[3].base = 10'h155; vecs[3].stall = 2; vecs[3].gaps = 1;
    vecs[3].beats = {32'h0F1E2D3C, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};
    vecs[3].exp_addr = {10'h156, 10'h155};
    vecs[3].exp_word = {64'h0F1E2D3C89ABCDEF, 64'h01234567DEADBEEF};

    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start_i = 1'($urandom);
      valid_i = 1'($urandom);
      data_i = $urandom;
      cfg_base_addr_i = 10'($urandom);
      cfg_num_words_i = 10'($urandom);
      tick();
    end
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_we", 64'(mem_we_o), 64'd0);
    chk("rst_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_wdata", mem_wdata_o, 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    start_i = 1'b0;
    valid_i = 1'b1;
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_ready", 64'(ready_o), 64'd0);
    chk("post_rst_busy", 64'(busy_o), 64'd0);
    valid_i = 1'b0;

    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      run_job(v, $sformatf("job%0d", i));
    end

    // Empty job
    done_cnt = 0;
    w0 = n_writes;
    start_i = 1'b1;
    cfg_base_addr_i = 10'h123;
    cfg_num_words_i = 10'd0;
    tick();
    start_i = 1'b0;
    chk("empty_done", 64'(done_o), 64'd1);
    chk("empty_busy", 64'(busy_o), 64'd0);
    tick();
    chk("empty_done_single", 64'(done_o), 64'd0);
    repeat (3) tick();
    chk("empty_no_write", 64'(n_writes - w0), 64'd0);
    chk("empty_done_count", 64'(done_cnt), 64'd1);

    // Start during RUN is ignored
    v = vecs[0];
    v.base = 10'h020;
    v.exp_addr = {10'h021, 10'h020};
    push_exp(v);
    done_cnt = 0;
    w0 = n_writes;
    start_i = 1'b1;
    cfg_base_addr_i = v.base;
    cfg_num_words_i = 10'd2;
    tick();
    start_i = 1'b0;
    send_beat(v.beats[0]);
    start_i = 1'b1;
    cfg_base_addr_i = 10'h300;
    cfg_num_words_i = 10'd5;
    send_beat(v.beats[1]);
    start_i = 1'b0;
    send_beat(v.beats[2]);
    send_beat(v.beats[3]);
    wait_done("restart_done");
    chk("restart_done_count", 64'(done_cnt), 64'd1);
    chk("restart_writes", 64'(n_writes - w0), 64'd2);
    chk("restart_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-job
    done_cnt = 0;
    w0 = n_writes;
    start_i = 1'b1;
    cfg_base_addr_i = 10'h040;
    cfg_num_words_i = 10'd2;
    tick();
    start_i = 1'b0;
    send_beat(32'hA5A5A5A5);
    rst = 1'b1;
    #2;
    chk("midrst_ready", 64'(ready_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_we", 64'(mem_we_o), 64'd0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("midrst_no_write", 64'(n_writes - w0), 64'd0);
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    v = vecs[0];
    run_job(v, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
